// File: rtl/sha_pkg.sv
// SHA-256 constants, controller state encoding and message-schedule sigma helpers.
package sha_pkg;

  localparam int WORD_S    = 32;
  localparam int BLK_WORDS = 32;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_EXPAND   = 3'd1;
  localparam logic [2:0] ST_P0_START = 3'd2;
  localparam logic [2:0] ST_P0_WAIT  = 3'd3;
  localparam logic [2:0] ST_P1_START = 3'd4;
  localparam logic [2:0] ST_P1_WAIT  = 3'd5;
  localparam logic [2:0] ST_FINAL    = 3'd6;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    EXPAND   = ST_EXPAND,
    P0_START = ST_P0_START,
    P0_WAIT  = ST_P0_WAIT,
    P1_START = ST_P1_START,
    P1_WAIT  = ST_P1_WAIT,
    FINAL    = ST_FINAL
  } state_t;

  localparam logic [8*WORD_S-1:0] H_INIT =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [WORD_S-1:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [WORD_S-1:0] rotr(input logic [WORD_S-1:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [WORD_S-1:0] small_sigma0(input logic [WORD_S-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_S-1:0] small_sigma1(input logic [WORD_S-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha_compress_ctrl_if.sv
// Block-in / hash-out handshake between a block source and the compression controller.
interface sha_compress_ctrl_if;
  import sha_pkg::*;

  logic                    blk_valid;
  logic                    blk_ready;
  logic [16*WORD_S-1:0]    blk_data;
  logic [8*WORD_S-1:0]     hin;
  logic [8*WORD_S-1:0]     hout;
  logic                    hout_valid;

  modport master (
    output blk_valid, blk_data, hin,
    input  blk_ready, hout, hout_valid
  );

  modport slave (
    input  blk_valid, blk_data, hin,
    output blk_ready, hout, hout_valid
  );
endinterface

// File: rtl/sha_msg_sched.sv
// SHA-256 message schedule: loads W0..W15, then expands one word per step into W16..W63.
module sha_msg_sched
  import sha_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic                          step,
  input  logic [16*WORD_S-1:0]          blk_data,
  input  logic                          pass,
  output logic [5:0]                    idx,
  output logic [BLK_WORDS*WORD_S-1:0]   w_pass
);

  logic [WORD_S-1:0] w_mem [64];
  logic [5:0]        idx_reg;
  logic [WORD_S-1:0] w_next;

  // Index arithmetic wraps in 6 bits; only t = 16..63 is ever stepped.
  assign w_next = small_sigma1(w_mem[idx_reg - 6'd2]) + w_mem[idx_reg - 6'd7]
                + small_sigma0(w_mem[idx_reg - 6'd15]) + w_mem[idx_reg - 6'd16];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) w_mem[i] <= '0;
      idx_reg <= '0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) w_mem[i] <= blk_data[(15 - i)*WORD_S +: WORD_S];
      idx_reg <= 6'd16;
    end else if (step) begin
      w_mem[idx_reg] <= w_next;
      idx_reg        <= idx_reg + 6'd1;
    end
  end

  assign idx = idx_reg;

  genvar gi;
  for (gi = 0; gi < BLK_WORDS; gi++) begin : g_wout
    assign w_pass[gi*WORD_S +: WORD_S] = pass ? w_mem[gi + BLK_WORDS] : w_mem[gi];
  end

endmodule

// File: rtl/sha_compress_ctrl.sv
// SHA-256 compression controller: expands the schedule, runs two 32-round engine
// passes and adds the chaining value to form the output hash.
module sha_compress_ctrl
  import sha_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  sha_compress_ctrl_if.slave          blk,
  output logic                        eng_en,
  output logic [8*WORD_S-1:0]         eng_state_o,
  output logic [BLK_WORDS*WORD_S-1:0] eng_K,
  output logic [BLK_WORDS*WORD_S-1:0] eng_W,
  input  logic [8*WORD_S-1:0]         eng_state_i,
  input  logic                        eng_done
);

  state_t              state_reg, state_next;
  logic                sched_load, sched_step, pass1;
  logic                load_p0, capture_p0, capture_final;
  logic [5:0]          sched_idx;
  logic [8*WORD_S-1:0] hin_reg, eng_state_reg, hout_reg, hout_sum;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // eng_done is only looked at in the WAIT states, so stray or early pulses are harmless.
  always_comb begin
    state_next     = state_reg;
    blk.blk_ready  = 1'b0;
    blk.hout_valid = 1'b0;
    eng_en         = 1'b0;
    sched_load     = 1'b0;
    sched_step     = 1'b0;
    pass1          = 1'b0;
    load_p0        = 1'b0;
    capture_p0     = 1'b0;
    capture_final  = 1'b0;
    case (state_reg)
      IDLE: begin
        blk.blk_ready = 1'b1;
        if (blk.blk_valid) begin
          sched_load = 1'b1;
          state_next = EXPAND;
        end
      end
      EXPAND: begin
        sched_step = 1'b1;
        if (sched_idx == 6'd63) begin
          load_p0    = 1'b1;
          state_next = P0_START;
        end
      end
      P0_START: begin
        eng_en     = 1'b1;
        state_next = P0_WAIT;
      end
      P0_WAIT: begin
        if (eng_done) begin
          capture_p0 = 1'b1;
          state_next = P1_START;
        end
      end
      P1_START: begin
        pass1      = 1'b1;
        eng_en     = 1'b1;
        state_next = P1_WAIT;
      end
      P1_WAIT: begin
        pass1 = 1'b1;
        if (eng_done) begin
          capture_final = 1'b1;
          state_next    = FINAL;
        end
      end
      FINAL: begin
        blk.hout_valid = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // hout is written on entry to FINAL so it is already current while hout_valid is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      hin_reg       <= '0;
      eng_state_reg <= '0;
      hout_reg      <= '0;
    end else begin
      if (sched_load)    hin_reg       <= blk.hin;
      if (load_p0)       eng_state_reg <= hin_reg;
      if (capture_p0)    eng_state_reg <= eng_state_i;
      if (capture_final) hout_reg      <= hout_sum;
    end
  end

  genvar gi;
  for (gi = 0; gi < 8; gi++) begin : g_final_add
    assign hout_sum[gi*WORD_S +: WORD_S] = hin_reg[gi*WORD_S +: WORD_S] + eng_state_i[gi*WORD_S +: WORD_S];
  end

  for (gi = 0; gi < BLK_WORDS; gi++) begin : g_kout
    assign eng_K[gi*WORD_S +: WORD_S] = pass1 ? K_TABLE[gi + BLK_WORDS] : K_TABLE[gi];
  end

  assign eng_state_o = eng_state_reg;
  assign blk.hout    = hout_reg;

  sha_msg_sched u_sched (
    .clk      (clk),
    .reset    (reset),
    .load     (sched_load),
    .step     (sched_step),
    .blk_data (blk.blk_data),
    .pass     (pass1),
    .idx      (sched_idx),
    .w_pass   (eng_W)
  );

endmodule

// File: doc/sha_compress_ctrl.md
SHA_COMPRESS_CTRL -- requirements
Module: sha_compress_ctrl

Interface
REQ-001 SHALL have clk, input, 1 bit: rising-edge clock for all state.
REQ-002 SHALL have reset, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have blk_valid, input, 1 bit: a 512-bit message block and its chaining value are offered.
REQ-004 SHALL have blk_ready, output, 1 bit: the controller accepts a block; a transfer occurs when blk_valid && blk_ready at a rising edge.
REQ-005 SHALL have blk_data, input, 512 bits: message block; W0 = [511:480], W15 = [31:0].
REQ-006 SHALL have hin, input, 256 bits: chaining value H0..H7; H0 = [255:224], H7 = [31:0].
REQ-007 SHALL have hout, output, 256 bits: result hash, packed the same as hin.
REQ-008 SHALL have hout_valid, output, 1 bit: one-cycle pulse when hout is updated.
REQ-009 SHALL have eng_en, output, 1 bit: one-cycle start pulse to the 32-round engine.
REQ-010 SHALL have eng_state_o, output, 256 bits: engine input state a..h; a = [255:224], h = [31:0].
REQ-011 SHALL have eng_K, output, 1024 bits: 32 round constants; word j = [32j+31:32j].
REQ-012 SHALL have eng_W, output, 1024 bits: 32 schedule words, packed the same as eng_K.
REQ-013 SHALL have eng_state_i, input, 256 bits: engine result a..h, packed the same as eng_state_o.
REQ-014 SHALL have eng_done, input, 1 bit: engine result valid pulse.

Function
REQ-015 SHALL implement FSM states IDLE, EXPAND, P0_START, P0_WAIT, P1_START, P1_WAIT, FINAL.
REQ-016 IDLE SHALL assert blk_ready; on transfer, SHALL latch W0..W15 and hin, then enter EXPAND.
REQ-017 EXPAND SHALL compute one word per cycle, Wt = s1(Wt-2) + Wt-7 + s0(Wt-15) + Wt-16 mod 2^32, for t = 16..63, taking exactly 48 cycles.
REQ-018 P0_START SHALL be one cycle: eng_en = 1, eng_state_o = latched hin, eng_K/eng_W = words 0..31; it SHALL then enter P0_WAIT.
REQ-019 P0_WAIT SHALL hold eng_K/eng_W stable, and on eng_done SHALL capture eng_state_i and enter P1_START.
REQ-020 P1_START/P1_WAIT SHALL behave the same as P0, with eng_state_o = captured pass-0 result and words 32..63.
REQ-021 FINAL SHALL be one cycle: hout word i = Hi + engine result word i (mod 2^32, no carry between words), hout_valid = 1, then enter IDLE.
REQ-022 Accept at edge T SHALL give eng_en high in cycle T+49 (after 48 cycles of EXPAND, cycles T+1..T+48); total latency SHALL be 49 + 2 + engine latencies.
REQ-023 blk_ready SHALL be low in every non-IDLE state; blk_valid SHALL be ignored while busy.
REQ-024 eng_done outside P0_WAIT/P1_WAIT SHALL be ignored.
REQ-025 eng_done coincident with eng_en in a START state SHALL be ignored.
REQ-026 hout SHALL hold its value until the next FINAL.
REQ-027 A block SHALL be acceptable in the cycle after FINAL, giving back-to-back operation.
REQ-028 eng_en SHALL never be high for two consecutive cycles.

Reset
REQ-029 On reset, the controller SHALL enter IDLE and the following SHALL be cleared: blk_ready=1, hout=0, hout_valid=0, eng_en=0, eng_state_o=0, and all schedule, latched-hin and captured-state storage=0.
REQ-030 Reset in any state SHALL abort the operation and produce no hout_valid; the next accepted block SHALL compute correctly.

Structure
REQ-031 Package sha_pkg SHALL hold the 64-entry K table, the initial H0..H7, WORD_S=32, BLK_WORDS=32, and the state-encoding localparams.
REQ-032 Schedule expansion (64x32 storage plus s0/s1 adder) SHALL be the sub-module sha_msg_sched, with load/step controls and a 0..63 word index.
REQ-033 The FSM, eng_state_o/hout registers and the final adder SHALL reside in sha_compress_ctrl.

Verification
REQ-034 "abc" padded block with hin = standard IV -> hout = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, hout_valid for exactly 1 cycle.
REQ-035 448-bit "abcdbcdecd...nopq" as two blocks, with block 2 using block-1 hout as hin -> hout = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-036 blk_valid held high continuously for 3 blocks -> exactly 3 transfers, 3 hout_valid pulses, and blk_ready low between accept and FINAL.
REQ-037 Engine model with 32- and 40-cycle done latency, plus spurious eng_done in IDLE/EXPAND -> identical hout, and eng_en pulses exactly at T+49 and one cycle after the first done.
REQ-038 Reset asserted in P1_WAIT, then "abc" block -> no hout_valid for the aborted block; correct "abc" digest produced.
